// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider, one quotient bit per cycle, for DIV/DIVU/REM/REMU
module seq_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIXUP,
        DONE
    } state_t;

    state_t state, state_next;

    // op_a starts as the dividend and is shifted left each iteration, so its
    // low end fills with quotient bits while its MSB feeds the remainder.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] part_rem;
    logic [CW-1:0]    count;
    logic             sgn;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             zero_div;
    logic             overflow;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             carry;
    logic             unused_diff_msb;

    assign accept   = (state == IDLE) && start;
    assign zero_div = (divisor == '0);
    assign overflow = is_signed
                   && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                   && (divisor == '1);

    // Trial subtraction as remainder + ~divisor + 1 at WIDTH+1 bits; the
    // carry-out is the "no borrow" flag. diff[WIDTH] is always 0 on commit.
    assign shifted = {part_rem, op_a[WIDTH-1]};
    assign {carry, diff} = {1'b0, shifted}
                         + {1'b0, 1'b1, ~op_b}
                         + {{(WIDTH+1){1'b0}}, 1'b1};
    assign unused_diff_msb = diff[WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (zero_div || overflow) begin
                        state_next = DONE;
                    end else begin
                        state_next = PREP;
                    end
                end
            end
            PREP: begin
                busy       = 1'b1;
                state_next = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (count == '0) begin
                    state_next = FIXUP;
                end
            end
            FIXUP: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a        <= '0;
            op_b        <= '0;
            part_rem    <= '0;
            count       <= '0;
            sgn         <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a        <= dividend;
                        op_b        <= divisor;
                        sgn         <= is_signed;
                        div_by_zero <= zero_div;
                        // Special cases resolve here so done can follow next cycle.
                        if (zero_div) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end else if (overflow) begin
                            quotient  <= dividend;
                            remainder <= '0;
                        end
                    end
                end
                PREP: begin
                    neg_q    <= sgn && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    neg_r    <= sgn && op_a[WIDTH-1];
                    if (sgn && op_a[WIDTH-1]) begin
                        op_a <= -op_a;
                    end
                    if (sgn && op_b[WIDTH-1]) begin
                        op_b <= -op_b;
                    end
                    part_rem <= '0;
                    count    <= CW'(WIDTH - 1);
                end
                ITER: begin
                    op_a  <= {op_a[WIDTH-2:0], carry};
                    count <= count - 1'b1;
                    if (carry) begin
                        part_rem <= diff[WIDTH-1:0];
                    end else begin
                        part_rem <= shifted[WIDTH-1:0];
                    end
                end
                FIXUP: begin
                    quotient  <= neg_q ? -op_a : op_a;
                    remainder <= neg_r ? -part_rem : part_rem;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    int n_checks;
    int n_fail;

    seq_divider #(.WIDTH(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, actual, expected);
        end
    endtask

    // Start at cycle 0, optionally pulse start with 9/3 at cycle inj while busy.
    task automatic run_op(input string tag, input logic sd, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] eq, input logic [63:0] er, input logic edz,
                          input int elat, input int inj);
        int   cyc;
        logic busy_ok;
        @(negedge clk);
        start     = 1'b1;
        is_signed = sd;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        start   = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (cyc < 200 && done !== 1'b1) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
            start = (cyc == inj);
            if (cyc == inj) begin
                dividend = 64'd9;
                divisor  = 64'd3;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(elat));
        check({tag, " busy_while_running"}, {63'd0, busy_ok}, 64'd1);
        check({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_by_zero"}, {63'd0, div_by_zero}, {63'd0, edz});
        @(negedge clk);
        check({tag, " done_one_cycle"}, {63'd0, done}, 64'd0);
        check({tag, " quotient_held"}, quotient, eq);
    endtask

    initial begin
        int  cyc;
        logic saw_done;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset quotient", quotient, 64'd0);
        check("reset remainder", remainder, 64'd0);
        check("reset div_by_zero", {63'd0, div_by_zero}, 64'd0);
        rst_n = 1'b1;

        run_op("u100/7", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 67, 0);
        run_op("s-7/2", 1'b1, -64'sd7, 64'd2, -64'sd3, -64'sd1, 1'b0, 67, 0);
        run_op("s7/-2", 1'b1, 64'd7, -64'sd2, -64'sd3, 64'd1, 1'b0, 67, 0);
        run_op("s-7/-2", 1'b1, -64'sd7, -64'sd2, 64'd3, -64'sd1, 1'b0, 67, 0);
        run_op("u_max/1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 67, 0);
        run_op("u_max/msb", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
               64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 67, 0);
        run_op("u5/0", 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1, 1, 0);
        run_op("s5/0", 1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1, 1, 0);
        run_op("s_ovf", 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 64'd0, 1'b0, 1, 0);
        run_op("busy_ignore", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 67, 10);
        run_op("after_ignore", 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 1'b0, 67, 0);

        // Reset in the middle of an operation.
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 64'd100;
        divisor   = 64'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst busy", {63'd0, busy}, 64'd0);
        check("midrst done", {63'd0, done}, 64'd0);
        check("midrst quotient", quotient, 64'd0);
        check("midrst remainder", remainder, 64'd0);
        check("midrst div_by_zero", {63'd0, div_by_zero}, 64'd0);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        check("midrst no_done", {63'd0, saw_done}, 64'd0);
        run_op("after_rst", 1'b1, -64'sd100, 64'd7, -64'sd14, -64'sd2, 1'b0, 67, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring divider for the M-extension DIV/DIVU/REM/REMU datapath in the execute stage.
- It is the subtractive counterpart of the 64-bit ripple adder.
- Each iteration is one trial subtraction, computed as the remainder plus the inverted divisor with carry-in 1, and produces one quotient bit per cycle.
- Start/done handshake with the pipeline stall logic; results are held until the next start.

Parameters:
WIDTH, 64, operand, quotient and remainder width in bits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  request; accepted only when busy=0.
is_signed  input  1  1 = DIV/REM (two's complement); 0 = DIVU/REMU.
dividend  input  WIDTH  numerator, sampled on an accepted start.
divisor  input  WIDTH  denominator, sampled on an accepted start.
busy  output  1  high from the cycle after acceptance until done.
done  output  1  one-cycle pulse; quotient and remainder are valid in this cycle.
quotient  output  WIDTH  result quotient, held after done.
remainder  output  WIDTH  result remainder, held after done.
div_by_zero  output  1  set with done when divisor==0; held until the next accepted start.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Applies mid-operation: the operation in progress is abandoned and no done is produced.
- States: IDLE, PREP, ITER, FIXUP, DONE.
- IDLE:
  - On start=1, latch the operands and is_signed.
  - divisor==0: next state is DONE with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
  - Signed overflow (is_signed, dividend=100..0, divisor=all ones): next state is DONE with quotient=dividend, remainder=0.
  - Otherwise: next state is PREP.
- PREP:
  - If is_signed, take the absolute value of each operand.
  - Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
  - Clear the partial remainder; set the iteration counter to WIDTH-1.
- ITER (WIDTH cycles):
  - Shift the partial remainder left, inserting the next dividend MSB.
  - Trial subtract the divisor. If there is no borrow (carry-out=1), commit the difference and set quotient bit=1; otherwise keep the partial remainder and set quotient bit=0.
  - The counter decrements each cycle; when it reaches 0, go to FIXUP.
- FIXUP:
  - Negate the quotient if neg_q; negate the remainder if neg_r.
  - The remainder sign always follows the dividend (RISC-V semantics).
- DONE:
  - done=1 for exactly one cycle; busy=0; next state is IDLE.
  - A start in the DONE cycle is ignored; the next acceptance is from IDLE.
- Latency (start accepted at cycle 0):
  - Normal: done at cycle WIDTH+3.
  - Divide-by-zero / overflow: done at cycle 1.
- busy is high in PREP, ITER and FIXUP.
- start while busy=1 is ignored, and the operands are not resampled.
- quotient, remainder and div_by_zero hold their values after done until the next accepted start. They may change only from PREP onward.
- All arithmetic is modulo 2^WIDTH.
  - The trial subtract is WIDTH+1 bits wide, so the MSB shifted out of the partial remainder is not lost.
  - Unsigned operands use the full range.

Test Plan:
- Unsigned, is_signed=0, 100 / 7, start at cycle 0:
  - busy=1 at cycles 1–66; done=1 only at cycle 67.
  - quotient=14, remainder=2, div_by_zero=0.
- Signed, -7 / 2:
  - quotient=0xFFFF_FFFF_FFFF_FFFD (-3), remainder=0xFFFF_FFFF_FFFF_FFFF (-1).
- Signed, 7 / -2:
  - quotient=-3, remainder=1.
- Unsigned, 0xFFFF_FFFF_FFFF_FFFF / 1:
  - quotient=all ones, remainder=0.
- Divide by zero, 5 / 0, signed and unsigned:
  - done at cycle 1; quotient=all ones, remainder=5, div_by_zero=1.
- Signed overflow, 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF:
  - done at cycle 1; quotient=0x8000_0000_0000_0000, remainder=0.
- Robustness, first part (start ignored while busy):
  - Start 100/7, then assert start with 9/3 at cycle 10.
  - Result must still be 14 r 2 at cycle 67.
  - A following start at cycle 69 of 9/3 yields 3 r 0 at cycle 69+67.
- Robustness, second part (reset mid-operation):
  - Drive rst_n=0 at cycle 30 of an operation.
  - Next cycle: busy=0 and outputs=0, with no done pulse.
  - A new start after reset completes normally.
